// File: rtl/seq_divider_8b.sv
// Sequential 8-bit by 4-bit unsigned restoring divider: one quotient bit per cycle.
// Start accepted in IDLE/DONE only; 9-cycle start-to-done latency, 1 cycle for divide-by-zero.
module seq_divider_8b (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [7:0] quotient,
   output logic [3:0] remainder,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t     r_state;
   logic [2:0] r_cnt;
   logic [7:0] r_dvd;
   logic [3:0] r_dvs;
   logic [3:0] r_pr;
   logic [7:0] r_q;
   logic [7:0] r_quotient;
   logic [3:0] r_remainder;
   logic       r_dbz;
   logic       r_busy;
   logic       r_done;

   logic [4:0] w_pr_sh;
   logic       w_ge;
   logic [3:0] w_pr_nx;
   logic [7:0] w_q_nx;
   logic       w_accept;

   // One restoring step; a non-restored remainder is always below the divisor, so bit 4 is zero.
   assign w_pr_sh  = {r_pr, r_dvd[7]};
   assign w_ge     = (w_pr_sh >= {1'b0, r_dvs});
   assign w_pr_nx  = w_ge ? 4'(w_pr_sh - {1'b0, r_dvs}) : w_pr_sh[3:0];
   assign w_q_nx   = {r_q[6:0], w_ge};
   assign w_accept = start && (r_state != ST_CALC);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 3'd0;
         r_dvd       <= 8'd0;
         r_dvs       <= 4'd0;
         r_pr        <= 4'd0;
         r_q         <= 8'd0;
         r_quotient  <= 8'd0;
         r_remainder <= 4'd0;
         r_dbz       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_CALC: begin
               r_dvd <= {r_dvd[6:0], 1'b0};
               r_pr  <= w_pr_nx;
               r_q   <= w_q_nx;
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt == 3'd7) begin
                  r_state     <= ST_DONE;
                  r_quotient  <= w_q_nx;
                  r_remainder <= w_pr_nx;
                  r_dbz       <= 1'b0;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
               end
            end
            default: begin
               if (w_accept) begin
                  r_dvd <= dividend;
                  r_dvs <= divisor;
                  r_cnt <= 3'd0;
                  r_pr  <= 4'd0;
                  r_q   <= 8'd0;
                  if (divisor == 4'd0) begin
                     // Divide-by-zero skips CALC and reports saturated quotient immediately.
                     r_state     <= ST_DONE;
                     r_quotient  <= 8'hFF;
                     r_remainder <= dividend[3:0];
                     r_dbz       <= 1'b1;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                  end else begin
                     r_state <= ST_CALC;
                     r_busy  <= 1'b1;
                     r_done  <= 1'b0;
                  end
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_8b.sv
// Directed and exhaustive checks of seq_divider_8b against hand-computed and model values.
module tb_seq_divider_8b;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int n_chk  = 0;
   int n_fail = 0;

   seq_divider_8b dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and wait for done, checking latency, busy length and results.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic ez,
                         input bit full);
      int lat;
      int nb;
      int both;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start = 1'b0;
      dividend = ~a;
      divisor  = ~b;
      lat  = 1;
      nb   = busy ? 1 : 0;
      both = (busy && done) ? 1 : 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
         if (busy) nb++;
         if (busy && done) both++;
      end
      chk({tag, "_lat"}, lat, (b == 4'd0) ? 1 : 9);
      chk({tag, "_q"}, quotient, eq);
      chk({tag, "_r"}, remainder, er);
      chk({tag, "_dbz"}, div_by_zero, ez);
      if (full) begin
         chk({tag, "_busycyc"}, nb, (b == 4'd0) ? 0 : 8);
         chk({tag, "_overlap"}, both, 0);
         tick();
         chk({tag, "_donepulse"}, done, 0);
         chk({tag, "_qhold"}, quotient, eq);
      end else begin
         tick();
      end
   endtask

   initial begin
      int nd;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = 8'd0;
      divisor  = 4'd0;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      rst = 1'b0;
      tick();

      run_op("nom_100_7", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b1);
      run_op("b_255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b1);
      run_op("b_15_15", 8'd15, 4'd15, 8'd1, 4'd0, 1'b0, 1'b1);
      run_op("b_3_9", 8'd3, 4'd9, 8'd0, 4'd3, 1'b0, 1'b1);
      run_op("dz_200_0", 8'd200, 4'd0, 8'hFF, 4'h8, 1'b1, 1'b1);
      run_op("b_0_5", 8'd0, 4'd5, 8'd0, 4'd0, 1'b0, 1'b1);

      // Start held through CALC with new operands; it must only re-issue in DONE.
      dividend = 8'd100;
      divisor  = 4'd7;
      start    = 1'b1;
      tick();
      dividend = 8'd255;
      divisor  = 4'd3;
      nd = 1;
      while (!done && nd < 20) begin
         tick();
         nd++;
      end
      chk("hold_lat", nd, 9);
      chk("hold_q", quotient, 14);
      chk("hold_r", remainder, 2);
      tick();
      start = 1'b0;
      chk("b2b_busy", busy, 1);
      chk("b2b_done", done, 0);
      nd = 1;
      while (!done && nd < 20) begin
         tick();
         nd++;
      end
      chk("b2b_lat", nd, 9);
      chk("b2b_q", quotient, 85);
      chk("b2b_r", remainder, 0);
      tick();

      // Reset during the 4th CALC cycle aborts the operation.
      dividend = 8'd100;
      divisor  = 4'd7;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("abort_busy_pre", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_q", quotient, 0);
      chk("abort_r", remainder, 0);
      chk("abort_dbz", div_by_zero, 0);
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) nd++;
      end
      chk("abort_nodone", nd, 0);
      run_op("post_9_2", 8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 1'b1);

      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            logic [7:0] eq;
            logic [3:0] er;
            if (b == 0) begin
               eq = 8'hFF;
               er = 4'(a);
            end else begin
               eq = 8'(a / b);
               er = 4'(a % b);
            end
            run_op("exh", 8'(a), 4'(b), eq, er, (b == 0), 1'b0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_divider_8b.md
SEQ_DIVIDER_8B -- requirements
Module: seq_divider_8b

Interface
REQ-001 The block SHALL have no parameters: dividend is 8 bits, divisor is 4 bits, quotient is 8 bits and remainder is 4 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division, sampled only when not busy.
REQ-005 The block SHALL have port dividend, input, 8 bits: unsigned dividend, captured on an accepted start.
REQ-006 The block SHALL have port divisor, input, 4 bits: unsigned divisor, captured on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that the results are valid.
REQ-009 The block SHALL have port quotient, output, 8 bits: registered unsigned quotient.
REQ-010 The block SHALL have port remainder, output, 4 bits: registered unsigned remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: registered flag set when the captured divisor was 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL be accepted: dividend and divisor are latched into internal working registers and the iteration counter is cleared.
REQ-014 On an accepted start with divisor!=0, the next state SHALL be CALC; with divisor==0, the next state SHALL be DONE directly.
REQ-015 Each CALC cycle SHALL perform one restoring step:
- 5-bit partial remainder pr = {pr[3:0], working dividend MSB}; working dividend shifts left by 1.
- If pr >= {1'b0, divisor}: pr = pr - divisor and the quotient LSB shifted in = 1; otherwise the LSB = 0.
REQ-016 CALC SHALL last exactly 8 cycles, using a counter from 0 to 7, and SHALL then move to DONE.
REQ-017 On the transition into DONE, quotient, remainder (pr[3:0]) and div_by_zero SHALL be loaded; they SHALL hold until the next transition into DONE.
REQ-018 For divisor==0, the results SHALL be quotient=8'hFF, remainder=dividend[3:0] and div_by_zero=1; the latency from start to done SHALL be 1 cycle.
REQ-019 For divisor!=0, div_by_zero SHALL be 0, and the results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor.
REQ-020 Latency: if start is sampled at edge N, busy SHALL be high after edges N..N+7 and done SHALL be high for exactly one cycle after edge N+8.
REQ-021 busy SHALL equal (state==CALC); done SHALL equal (state==DONE); busy and done SHALL never be high together.
REQ-022 DONE SHALL last one cycle, then go to IDLE, unless start=1 in DONE, in which case the new operation is accepted (back-to-back issue).
REQ-023 start while in CALC SHALL be ignored, with no effect on the working registers or outputs.
REQ-024 Changes on dividend or divisor after acceptance SHALL NOT affect the operation in flight.
REQ-025 Input values are unconstrained; all 256x16 operand combinations SHALL be legal.

Reset
REQ-026 When rst=1 at a rising edge, the state SHALL go to IDLE and the counter, working registers, quotient, remainder, div_by_zero, busy and done SHALL all become 0.
REQ-027 rst SHALL take priority over start.
REQ-028 rst during CALC or DONE SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-029 After rst deasserts, the first start SHALL be accepted normally.

Verification
REQ-030 Nominal division: dividend=100, divisor=7, start for one cycle -> busy for 8 cycles, then done for 1 cycle with quotient=14, remainder=2, div_by_zero=0.
REQ-031 Boundary cases:
- 255/1 -> quotient=255, remainder=0.
- 15/15 -> quotient=1, remainder=0.
- 3/9 -> quotient=0, remainder=3.
- All cases: latency 9 cycles from the sampling edge to done.
REQ-032 Divide by zero: dividend=200 (8'hC8), divisor=0 -> done 1 cycle after the sampling edge, busy never high, quotient=8'hFF, remainder=4'h8, div_by_zero=1.
REQ-033 Ignored start: start=1 held with new operands during CALC of 100/7 -> results are still 14/2; a held start re-issues in DONE, giving back-to-back operations with no IDLE cycle between them.
REQ-034 Reset mid-operation: rst=1 at the 4th CALC cycle -> busy=0, done=0 and all outputs=0 on the next cycle; no done follows; a subsequent 9/2 yields quotient=4, remainder=1.
REQ-035 Exhaustive check: all 4096 operand pairs are checked against a reference model (quotient = dividend/divisor and remainder = dividend%divisor for divisor!=0; the REQ-018 values for divisor=0).
